// File: rtl/cache_line_xfer_ctrl.sv
// Purpose : moves one cache line between a cache bank and the memory bus on a miss:
//           refills the line in BEATS beats and writes back a dirty victim, with the
//           write-back ordered before (WB_FIRST=1) or after (WB_FIRST=0) the refill.
// Latency : busy rises the cycle after miss_req is taken; fill_wen follows each
//           mem_rvalid by one cycle; DONE lasts one cycle before IDLE.
// Backpressure: each beat request is held until mem_rvalid/mem_wvalid; a beat that
//           sees no valid within TIMEOUT cycles aborts the transfer and sets err.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   miss_req/_addr/_set  miss request, any byte address in the line, fill way
//   victim_dirty/_addr/_data  victim line to write back (word 0 in LSBs)
//   busy               transfer in progress (READ or WRITE)
//   fill_wen/_addr/_set/_data  one refill beat into the cache
//   fill_done, wb_done one-cycle completion pulses; err sticky timeout flag
//   mem_ren/_raddr/_rvalid/_rdata  memory read beat channel
//   mem_wen/_waddr/_wdata/_wmask/_wvalid  memory write beat channel
module cache_line_xfer_ctrl #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int BANK_NUM   = 4,
   parameter int BUS_WORDS  = 2,
   parameter int WB_FIRST   = 0,
   parameter int TIMEOUT    = 255
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              miss_req,
   input  logic [ADDR_WIDTH-1:0]             miss_addr,
   input  logic                              miss_set,
   input  logic                              victim_dirty,
   input  logic [ADDR_WIDTH-1:0]             victim_addr,
   input  logic [BANK_NUM*DATA_WIDTH-1:0]    victim_data,
   output logic                              busy,
   output logic                              fill_wen,
   output logic [ADDR_WIDTH-1:0]             fill_addr,
   output logic                              fill_set,
   output logic [BUS_WORDS*DATA_WIDTH-1:0]   fill_data,
   output logic                              fill_done,
   output logic                              wb_done,
   output logic                              err,
   output logic                              mem_ren,
   output logic [ADDR_WIDTH-1:0]             mem_raddr,
   input  logic                              mem_rvalid,
   input  logic [BUS_WORDS*DATA_WIDTH-1:0]   mem_rdata,
   output logic                              mem_wen,
   output logic [ADDR_WIDTH-1:0]             mem_waddr,
   output logic [BUS_WORDS*DATA_WIDTH-1:0]   mem_wdata,
   output logic [BUS_WORDS*DATA_WIDTH/8-1:0] mem_wmask,
   input  logic                              mem_wvalid
);

   localparam int BEATS      = BANK_NUM / BUS_WORDS;
   localparam int LINE_W     = BANK_NUM * DATA_WIDTH;
   localparam int BEAT_W     = BUS_WORDS * DATA_WIDTH;
   localparam int LINE_BYTES = LINE_W / 8;
   localparam int BEAT_BYTES = BEAT_W / 8;
   localparam int BCW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TCW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(BEAT_BYTES);
   localparam logic [BCW-1:0]        LAST_BEAT = BCW'(BEATS - 1);
   localparam logic [TCW-1:0]        TMO_LAST  = TCW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic [ADDR_WIDTH-1:0]   line_base;
   logic [ADDR_WIDTH-1:0]   victim_base;
   logic [LINE_W-1:0]       victim_line;
   logic                    dirty_q;
   logic                    set_q;
   logic [BCW-1:0]          beat;
   logic [TCW-1:0]          tmo;

   logic [ADDR_WIDTH-1:0]   beat_offset;
   logic [LINE_W-1:0]       victim_shift;
   logic                    beat_last;
   logic                    tmo_expired;

   assign beat_offset  = ADDR_WIDTH'(beat) * BEAT_STEP;
   assign victim_shift = victim_line >> (BEAT_W * int'(beat));
   assign beat_last    = (beat == LAST_BEAT);
   // The valid arriving in the last allowed cycle still wins over the abort.
   assign tmo_expired  = (tmo == TMO_LAST);
   assign fill_set     = set_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and bus-facing outputs; all address/data outputs read 0 outside
   // their active phase so IDLE (and therefore reset) drives every output low.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      mem_ren   = 1'b0;
      mem_raddr = '0;
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      case (state)
         IDLE: begin
            if (miss_req) begin
               state_nxt = (victim_dirty && (WB_FIRST != 0)) ? WRITE : READ;
            end
         end
         READ: begin
            busy      = 1'b1;
            mem_ren   = 1'b1;
            mem_raddr = line_base + beat_offset;
            if (mem_rvalid) begin
               if (beat_last) begin
                  state_nxt = (dirty_q && (WB_FIRST == 0)) ? WRITE : DONE;
               end
            end else if (tmo_expired) begin
               state_nxt = DONE;
            end
         end
         WRITE: begin
            busy      = 1'b1;
            mem_wen   = 1'b1;
            mem_waddr = victim_base + beat_offset;
            mem_wdata = victim_shift[BEAT_W-1:0];
            mem_wmask = '1;
            if (mem_wvalid) begin
               if (beat_last) begin
                  state_nxt = (WB_FIRST != 0) ? READ : DONE;
               end
            end else if (tmo_expired) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Latched line context, beat/timeout counters and registered cache-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_base   <= '0;
         victim_base <= '0;
         victim_line <= '0;
         dirty_q     <= 1'b0;
         set_q       <= 1'b0;
         beat        <= '0;
         tmo         <= '0;
         err         <= 1'b0;
         fill_wen    <= 1'b0;
         fill_addr   <= '0;
         fill_data   <= '0;
         fill_done   <= 1'b0;
         wb_done     <= 1'b0;
      end else begin
         fill_wen  <= 1'b0;
         fill_done <= 1'b0;
         wb_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (miss_req) begin
                  line_base   <= miss_addr & ~LINE_MASK;
                  victim_base <= victim_addr & ~LINE_MASK;
                  victim_line <= victim_data;
                  dirty_q     <= victim_dirty;
                  set_q       <= miss_set;
                  err         <= 1'b0;
                  beat        <= '0;
                  tmo         <= '0;
               end
            end
            READ: begin
               if (mem_rvalid) begin
                  fill_wen  <= 1'b1;
                  fill_addr <= mem_raddr;
                  fill_data <= mem_rdata;
                  tmo       <= '0;
                  if (beat_last) begin
                     beat      <= '0;
                     fill_done <= 1'b1;
                  end else begin
                     beat <= beat + BCW'(1);
                  end
               end else if (tmo_expired) begin
                  err  <= 1'b1;
                  beat <= '0;
                  tmo  <= '0;
               end else begin
                  tmo <= tmo + TCW'(1);
               end
            end
            WRITE: begin
               if (mem_wvalid) begin
                  tmo <= '0;
                  if (beat_last) begin
                     beat    <= '0;
                     wb_done <= 1'b1;
                  end else begin
                     beat <= beat + BCW'(1);
                  end
               end else if (tmo_expired) begin
                  err  <= 1'b1;
                  beat <= '0;
                  tmo  <= '0;
               end else begin
                  tmo <= tmo + TCW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/cache_line_xfer_ctrl.md
Name: cache_line_xfer_ctrl

Overview:
- Parametrised cache-to-memory transfer engine; next-generation miss-handling controller sitting between a cache bank and the memory bus.
- On a miss it refills one cache line from memory as BEATS bus beats and writes back a dirty victim line.
- Write-back order is selectable: before or after the refill.
- Adds a per-beat response timeout with abort and error reporting.

Parameters:
- ADDR_WIDTH, 64, address width in bits.
- DATA_WIDTH, 64, cache word width in bits.
- BANK_NUM, 4, words per cache line.
- BUS_WORDS, 2, words per memory beat. Must divide BANK_NUM. BEATS = BANK_NUM/BUS_WORDS, BEATS ≥ 1.
- WB_FIRST, 0, mode select: 1 = write back the victim before the refill; 0 = refill first, then write back.
- TIMEOUT, 255, maximum cycles to wait for rvalid/wvalid on one beat.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- miss_req  in  1  miss request from the bank; sampled only in IDLE.
- miss_addr  in  ADDR_WIDTH  missing address (any byte within the line).
- miss_set  in  1  way select for the fill.
- victim_dirty  in  1  victim line needs write-back.
- victim_addr  in  ADDR_WIDTH  victim line address.
- victim_data  in  BANK_NUM*DATA_WIDTH  victim line; word 0 in the LSBs.
- busy  out  1  a transfer is in progress.
- fill_wen  out  1  write one beat into the cache.
- fill_addr  out  ADDR_WIDTH  beat-aligned address for fill_wen.
- fill_set  out  1  latched miss_set.
- fill_data  out  BUS_WORDS*DATA_WIDTH  refill beat data.
- fill_done  out  1  one-cycle pulse: refill complete.
- wb_done  out  1  one-cycle pulse: write-back complete.
- err  out  1  sticky timeout flag.
- mem_ren  out  1  read request.
- mem_raddr  out  ADDR_WIDTH  read address.
- mem_rvalid  in  1  read beat returned.
- mem_rdata  in  BUS_WORDS*DATA_WIDTH  read data.
- mem_wen  out  1  write request.
- mem_waddr  out  ADDR_WIDTH  write address.
- mem_wdata  out  BUS_WORDS*DATA_WIDTH  write data.
- mem_wmask  out  BUS_WORDS*DATA_WIDTH/8  byte mask.
- mem_wvalid  in  1  write beat accepted.

Behaviour:
- Constants: LINE_BYTES = BANK_NUM*DATA_WIDTH/8; BEAT_BYTES = BUS_WORDS*DATA_WIDTH/8.
- Reset (asynchronous, any time, including mid-transfer):
  - State goes to IDLE.
  - Every output is 0, including err.
  - Beat counter and timeout counter cleared; latched line discarded.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - On miss_req=1, latch on that edge: line base = miss_addr with the low log2(LINE_BYTES) bits zeroed; miss_set; victim_dirty; victim_addr (aligned the same way); victim_data. Clear err.
  - Next state: WRITE if victim_dirty and WB_FIRST=1, otherwise READ.
  - busy goes to 1 the cycle after acceptance.
- READ:
  - mem_ren=1 and mem_raddr = base + beat*BEAT_BYTES, held stable until mem_rvalid=1.
  - On each rvalid edge: fill_wen=1 for the next cycle only, with fill_data=mem_rdata, fill_addr = that beat's address, fill_set = latched set. The beat counter then increments.
  - mem_ren stays high across beats; the address advances in the cycle after rvalid.
  - After the last beat: mem_ren drops; fill_done pulses in the same cycle as the final fill_wen.
  - Next state: WRITE if dirty and WB_FIRST=0; otherwise WRITE already done, or clean victim → DONE.
- WRITE:
  - mem_wen=1, mem_waddr = victim base + beat*BEAT_BYTES, mem_wdata = latched victim words [beat*BUS_WORDS +: BUS_WORDS], mem_wmask all ones.
  - Signals held until mem_wvalid=1, then advance to the next beat.
  - After the last beat: mem_wen drops; wb_done pulses for one cycle.
  - Next state: READ if WB_FIRST=1, else DONE.
  - Write-back uses the copy latched at acceptance; later victim_data changes are ignored.
- DONE: one cycle, busy=0, then IDLE. A new miss is accepted at the earliest in the cycle after DONE.
- Ignored inputs:
  - miss_req while busy or in DONE.
  - mem_rvalid while mem_ren=0; mem_wvalid while mem_wen=0.
- Timeout:
  - Counter resets at each beat start and on every valid.
  - If it reaches TIMEOUT with no valid: drop mem_ren/mem_wen and set err=1.
  - No fill_done or wb_done is issued for the aborted phase; go to DONE.
- BEATS=1 is legal: a single beat per phase.

Test Plan:
- Clean miss, WB_FIRST=0, miss_addr=0x1038, rvalid 3 cycles after each request → raddr 0x1020 then 0x1030; two fill_wen with those addrs; fill_done on the second; no mem_wen; busy high from the cycle after miss_req through the last fill.
- Dirty miss, WB_FIRST=0, victim_addr=0x2000, victim words 0xA..0xD → READ beats first; then mem_wdata {0xB,0xA}@0x2000 and {0xD,0xC}@0x2010; wmask 0xFFFF; wb_done pulse, then DONE.
- Same stimulus with WB_FIRST=1 → both write beats complete before the first mem_ren; fill_done is the last event.
- TIMEOUT=8, rvalid never asserted → mem_ren drops after 8 cycles; err=1 and stays 1; no fill_done; the next miss_req clears err.
- miss_req held high during a transfer, plus a spurious rvalid in IDLE → exactly one transfer; no fill_wen from the spurious valid.
- rst asserted mid-WRITE (beat 1) → all outputs 0 immediately; a fresh miss afterwards starts at beat 0.
